// File: rtl/sat_div_16bit.sv
`default_nettype none
// ============================================================================
// Module   : sat_div_16bit
// Purpose  : Multi-cycle signed divider for the ALU long-latency path.
//            Restoring shift-subtract core producing one quotient bit per
//            clock, with saturating results (0x7FFF / 0x8000) instead of
//            wrap-around, and a start/busy/done handshake for stall logic.
// Ports    : clk         - system clock, rising edge
//            rst         - asynchronous active-high reset
//            start       - operation request, sampled only in IDLE
//            A, B        - signed dividend / divisor (stable at accept edge)
//            busy        - high while the operation is in ITER or FIN
//            done        - one-cycle pulse, results valid from this cycle
//            Quot, Rem   - signed quotient (toward zero) / remainder
//            div_by_zero - last completed operation had B == 0
//            ovfl        - last completed quotient saturated (MIN / -1)
// Options  : `define SAT_DIV_FAST_BYPASS_EN sends divide-by-zero and the
//            MIN/-1 overflow case straight from IDLE to FIN.
// Revision : 1.0 - initial release
// ============================================================================
module sat_div_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quot,
   output logic [WIDTH-1:0] Rem,
   output logic             div_by_zero,
   output logic             ovfl
);

   localparam int              CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]   C_CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] C_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;      // dividend magnitude, quotient shifts in at LSB
   logic [WIDTH-1:0] r_rem;      // partial remainder, always < |B|
   logic [WIDTH:0]   r_mag_b;    // |B| with one extra bit so |0x8000| fits
   logic [WIDTH-1:0] r_a;        // original dividend, needed for B==0 result
   logic             r_neg_q;
   logic             r_bzero;
   logic             r_ovf;
   logic             r_done;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remo;
   logic             r_dbz;
   logic             r_ovfl;

   logic             w_accept;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH:0]   w_mag_b;
   logic             w_b_zero;
   logic             w_ovf_case;
   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_sub;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   // A start coinciding with the done pulse is deliberately not accepted.
   assign w_accept   = (r_state == S_IDLE) && start && !r_done;

   // Two's-complement magnitude; 0x8000 maps to unsigned 0x8000.
   assign w_mag_a    = A[WIDTH-1] ? (~A + 1'b1) : A;
   assign w_mag_b    = {1'b0, (B[WIDTH-1] ? (~B + 1'b1) : B)};
   assign w_b_zero   = (B == '0);
   assign w_ovf_case = (A == C_MIN) && (B == '1);

   // Restoring step. When w_ge holds the difference is below |B| <= 2^(W-1),
   // so a WIDTH-bit subtraction of the low bits is exact.
   assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge       = (w_rem_sh >= r_mag_b);
   assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_mag_b[WIDTH-1:0];

   // Sign application and saturation overrides for the FIN cycle.
   always_comb begin
      w_q_fin = r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
      w_r_fin = r_a[WIDTH-1] ? (~r_rem + 1'b1) : r_rem;
      if (r_bzero) begin
         w_q_fin = r_a[WIDTH-1] ? C_MIN : C_MAX;
         w_r_fin = r_a;
      end else if (r_ovf) begin
         w_q_fin = C_MAX;
         w_r_fin = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef SAT_DIV_FAST_BYPASS_EN
               // Saturated cases need no iterations.
               w_state_nxt = (w_b_zero || w_ovf_case) ? S_FIN : S_ITER;
`else
               w_state_nxt = S_ITER;
`endif
            end
         end
         S_ITER: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dvd   <= '0;
         r_rem   <= '0;
         r_mag_b <= '0;
         r_a     <= '0;
         r_neg_q <= 1'b0;
         r_bzero <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_remo  <= '0;
         r_dbz   <= 1'b0;
         r_ovfl  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == S_FIN);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dvd   <= w_mag_a;
                  r_rem   <= '0;
                  r_mag_b <= w_mag_b;
                  r_a     <= A;
                  r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_bzero <= w_b_zero;
                  r_ovf   <= w_ovf_case;
                  r_cnt   <= C_CNT_LAST;
               end
            end
            S_ITER: begin
               r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
               r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
            end
            S_FIN: begin
               r_quot <= w_q_fin;
               r_remo <= w_r_fin;
               r_dbz  <= r_bzero;
               r_ovfl <= r_ovf && !r_bzero;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign Quot        = r_quot;
   assign Rem         = r_remo;
   assign div_by_zero = r_dbz;
   assign ovfl        = r_ovfl;

endmodule
`default_nettype wire
